// File: rtl/led_pwm_driver.sv
// Multi-channel LED brightness engine: shared prescaler and PWM counter,
// per-channel off / static / blink / breathe modes loaded by a write port.
module led_pwm_driver #(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESC_DIV     = 1024,
  parameter int unsigned BLINK_PERIODS = 64,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic [NUM_CH-1:0]   led,
  output logic                period_start
);

  localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int unsigned BCNT_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
  localparam logic [BCNT_W-1:0]   BCNT_LAST  = BCNT_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = '1;
  localparam logic [NUM_CH-1:0]   LED_OFF    = {NUM_CH{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PRESC_W-1:0]  presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                tick;
  logic                wrap;
  logic                wr_hit;

  mode_e               mode_q     [NUM_CH];
  logic [PWM_BITS-1:0] level_q    [NUM_CH];
  logic [PWM_BITS-1:0] shadow_q   [NUM_CH];
  logic                blink_off_q[NUM_CH];
  logic [BCNT_W-1:0]   bcnt_q     [NUM_CH];
  logic [PWM_BITS-1:0] ramp_q     [NUM_CH];
  logic                dir_dn_q   [NUM_CH];

  logic                step_up    [NUM_CH];
  logic [PWM_BITS-1:0] ramp_nxt   [NUM_CH];
  logic                dir_dn_nxt [NUM_CH];
  logic [PWM_BITS-1:0] duty_eff   [NUM_CH];

  assign tick   = (presc_q == PRESC_LAST);
  assign wrap   = tick && (pwm_cnt_q == PWM_LAST);
  assign wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

  // Shared timebase: prescaler, PWM counter and the wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      period_start <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + PRESC_W'(1);
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      end
      period_start <= wrap;
    end
  end

  // Next breathe step and the duty each channel would load at the next wrap.
  // Breathe loads the stepped ramp, so the first period after a write is lit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      step_up[i]    = 1'b0;
      ramp_nxt[i]   = ramp_q[i];
      dir_dn_nxt[i] = dir_dn_q[i];
      duty_eff[i]   = '0;

      if (ramp_q[i] > level_q[i]) begin
        ramp_nxt[i]   = level_q[i];
        dir_dn_nxt[i] = 1'b1;
      end else if (level_q[i] == '0) begin
        ramp_nxt[i]   = '0;
        dir_dn_nxt[i] = 1'b0;
      end else begin
        step_up[i]  = dir_dn_q[i] ? (ramp_q[i] == '0) : (ramp_q[i] != level_q[i]);
        ramp_nxt[i] = step_up[i] ? ramp_q[i] + PWM_BITS'(1) : ramp_q[i] - PWM_BITS'(1);
        if (ramp_nxt[i] == level_q[i]) begin
          dir_dn_nxt[i] = 1'b1;
        end else if (ramp_nxt[i] == '0) begin
          dir_dn_nxt[i] = 1'b0;
        end else begin
          dir_dn_nxt[i] = !step_up[i];
        end
      end

      case (mode_q[i])
        MODE_OFF:     duty_eff[i] = '0;
        MODE_STATIC:  duty_eff[i] = level_q[i];
        MODE_BLINK:   duty_eff[i] = blink_off_q[i] ? '0 : level_q[i];
        MODE_BREATHE: duty_eff[i] = ramp_nxt[i];
        default:      duty_eff[i] = '0;
      endcase
    end
  end

  // Per-channel config, wrap-time shadow load, pattern state and output compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i]      <= MODE_OFF;
        level_q[i]     <= '0;
        shadow_q[i]    <= '0;
        blink_off_q[i] <= 1'b0;
        bcnt_q[i]      <= '0;
        ramp_q[i]      <= '0;
        dir_dn_q[i]    <= 1'b0;
      end
      led <= LED_OFF;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wrap) begin
          shadow_q[i] <= duty_eff[i];
          if (mode_q[i] == MODE_BLINK) begin
            if (bcnt_q[i] == BCNT_LAST) begin
              bcnt_q[i]      <= '0;
              blink_off_q[i] <= !blink_off_q[i];
            end else begin
              bcnt_q[i] <= bcnt_q[i] + BCNT_W'(1);
            end
          end
          if (mode_q[i] == MODE_BREATHE) begin
            ramp_q[i]   <= ramp_nxt[i];
            dir_dn_q[i] <= dir_dn_nxt[i];
          end
        end
        // A write overrides any same-edge pattern step; its shadow effect waits a wrap.
        if (wr_hit && (wr_ch == 4'(i))) begin
          mode_q[i]      <= mode_e'(wr_mode);
          level_q[i]     <= wr_level;
          blink_off_q[i] <= 1'b0;
          bcnt_q[i]      <= '0;
          ramp_q[i]      <= '0;
          dir_dn_q[i]    <= 1'b0;
        end
        led[i] <= (pwm_cnt_q < shadow_q[i]) ^ ACTIVE_LOW;
      end
    end
  end

endmodule
